// File: rtl/jedro_1_test_monitor.sv
// Self-checking program monitor for jedro_1 core tests: waits for halt or timeout, drains,
// then compares register-file entries against expected values. Option: JEDRO_1_TEST_MON_STOP_ON_FAIL_EN.
module jedro_1_test_monitor #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_CHECKS     = 3,
  parameter int unsigned MAX_CYCLES     = 64,
  parameter int unsigned DRAIN_CYCLES   = 3
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         start_i,
  input  logic                                         halt_i,
  input  logic [NUM_CHECKS*REG_ADDR_WIDTH-1:0]         chk_addr_i,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0]             chk_data_i,
  output logic [REG_ADDR_WIDTH-1:0]                    rf_addr_o,
  input  logic [DATA_WIDTH-1:0]                        rf_data_i,
  output logic                                         done_o,
  output logic                                         pass_o,
  output logic                                         timeout_o,
  output logic [$clog2(NUM_CHECKS+1)-1:0]              err_cnt_o,
  output logic [((NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1)-1:0] fail_idx_o,
  output logic [DATA_WIDTH-1:0]                        fail_data_o
);

  localparam int unsigned ERR_W      = $clog2(NUM_CHECKS + 1);
  localparam int unsigned IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int unsigned CNT_MAX    = (MAX_CYCLES > DRAIN_CYCLES) ? MAX_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned RUN_LAST   = MAX_CYCLES - 1;
  localparam int unsigned DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int unsigned IDX_LAST   = NUM_CHECKS - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ERR_W-1:0]        err_q, err_d;
  logic [IDX_W-1:0]        fidx_q, fidx_d;
  logic [DATA_WIDTH-1:0]   fdata_q, fdata_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    to_q, to_d;

  logic [REG_ADDR_WIDTH-1:0] exp_addr;
  logic [DATA_WIDTH-1:0]     exp_data;
  logic                      mismatch;
  logic                      stop_check;

  // Select the (addr, expected) pair for the current check index
  always_comb begin
    exp_addr = '0;
    exp_data = '0;
    for (int k = 0; k < int'(NUM_CHECKS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        exp_addr = chk_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        exp_data = chk_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign mismatch  = (rf_data_i != exp_data);
  assign rf_addr_o = (state_q == S_CHECK) ? exp_addr : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    err_d      = err_q;
    fidx_d     = fidx_q;
    fdata_d    = fdata_q;
    done_d     = done_q;
    pass_d     = pass_q;
    to_d       = to_q;
    stop_check = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          cnt_d   = '0;
          idx_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          fdata_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          to_d    = 1'b0;
        end
      end

      S_RUN: begin
        if (!start_i) begin
          state_d = S_IDLE;
        end else if (halt_i || (cnt_q == CNT_W'(RUN_LAST))) begin
          // Halt takes priority over a simultaneous budget expiry
          to_d    = !halt_i;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (DRAIN_CYCLES == 0) ? S_CHECK : S_DRAIN;
        end else if (cnt_q != CNT_W'(CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DRAIN: begin
        if (!start_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(DRAIN_LAST)) begin
          state_d = S_CHECK;
          idx_d   = '0;
        end else if (cnt_q != CNT_W'(CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CHECK: begin
        if (!start_i) begin
          state_d = S_IDLE;
        end else begin
          if (mismatch) begin
            if (err_q != ERR_W'(NUM_CHECKS)) begin
              err_d = err_q + ERR_W'(1);
            end
            if (err_q == '0) begin
              fidx_d  = idx_q;
              fdata_d = rf_data_i;
            end
          end
`ifdef JEDRO_1_TEST_MON_STOP_ON_FAIL_EN
          stop_check = mismatch || (idx_q == IDX_W'(IDX_LAST));
`else
          stop_check = (idx_q == IDX_W'(IDX_LAST));
`endif
          if (stop_check) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0) && !to_q;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_DONE: begin
        // Results stay visible in IDLE until the next run starts
        if (!start_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort from an active phase discards partial results
    if ((state_q == S_RUN || state_q == S_DRAIN || state_q == S_CHECK) && !start_i) begin
      cnt_d   = '0;
      idx_d   = '0;
      err_d   = '0;
      fidx_d  = '0;
      fdata_d = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      to_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fdata_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fdata_q <= fdata_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = to_q;
  assign err_cnt_o   = err_q;
  assign fail_idx_o  = fidx_q;
  assign fail_data_o = fdata_q;

endmodule

// File: tb/tb_jedro_1_test_monitor.sv
// Directed table-driven bench for jedro_1_test_monitor; a second instance covers DRAIN_CYCLES=0.
module tb_jedro_1_test_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt;
  logic [14:0] chk_addr;
  logic [95:0] chk_data;
  logic [31:0] rf [32];

  logic [4:0]  a3_addr, a0_addr;
  logic [31:0] a3_data, a0_data;
  logic        a3_done, a3_pass, a3_to, a0_done, a0_pass, a0_to;
  logic [1:0]  a3_err, a3_fidx, a0_err, a0_fidx;
  logic [31:0] a3_fdata, a0_fdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign a3_data = rf[a3_addr];
  assign a0_data = rf[a0_addr];

  jedro_1_test_monitor #(.DRAIN_CYCLES(3)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .halt_i(halt),
    .chk_addr_i(chk_addr), .chk_data_i(chk_data),
    .rf_addr_o(a3_addr), .rf_data_i(a3_data),
    .done_o(a3_done), .pass_o(a3_pass), .timeout_o(a3_to),
    .err_cnt_o(a3_err), .fail_idx_o(a3_fidx), .fail_data_o(a3_fdata)
  );

  jedro_1_test_monitor #(.DRAIN_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .halt_i(halt),
    .chk_addr_i(chk_addr), .chk_data_i(chk_data),
    .rf_addr_o(a0_addr), .rf_data_i(a0_data),
    .done_o(a0_done), .pass_o(a0_pass), .timeout_o(a0_to),
    .err_cnt_o(a0_err), .fail_idx_o(a0_fidx), .fail_data_o(a0_fdata)
  );

  typedef struct {
    int          h;        // RUN cycle with halt high, -1 = never
    logic [31:0] x1, x2, x3;
    int          lat3, lat0;  // edges after RUN entry until done_o
    logic        pass, to;
    int          err, fidx;
    logic [31:0] fdata;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_case(input int vi, input vec_t v);
    int n, l3, l0;
    rf[1] = v.x1; rf[2] = v.x2; rf[3] = v.x3;
    start = 1'b1;
    tick();
    chk($sformatf("v%0d run_done_clear", vi), 32'(a3_done), 32'd0);
    chk($sformatf("v%0d run_addr_zero", vi), 32'(a3_addr), 32'd0);
    n = 0; l3 = -1; l0 = -1;
    while ((l3 < 0 || l0 < 0) && n < 200) begin
      halt = (n == v.h);
      tick();
      n++;
      if (l3 < 0 && a3_done) l3 = n;
      if (l0 < 0 && a0_done) l0 = n;
    end
    halt = 1'b0;
    chk($sformatf("v%0d lat_d3", vi), 32'(l3), 32'(v.lat3));
    chk($sformatf("v%0d lat_d0", vi), 32'(l0), 32'(v.lat0));
    chk($sformatf("v%0d pass", vi), 32'(a3_pass), 32'(v.pass));
    chk($sformatf("v%0d timeout", vi), 32'(a3_to), 32'(v.to));
    chk($sformatf("v%0d err_cnt", vi), 32'(a3_err), 32'(v.err));
    chk($sformatf("v%0d fail_idx", vi), 32'(a3_fidx), 32'(v.fidx));
    chk($sformatf("v%0d fail_data", vi), a3_fdata, v.fdata);
    chk($sformatf("v%0d d0_pass", vi), 32'(a0_pass), 32'(v.pass));
    chk($sformatf("v%0d d0_err_cnt", vi), 32'(a0_err), 32'(v.err));
    chk($sformatf("v%0d d0_timeout", vi), 32'(a0_to), 32'(v.to));
    // halt outside RUN must not disturb held results
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk($sformatf("v%0d done_hold", vi), 32'(a3_done), 32'd1);
    chk($sformatf("v%0d err_hold", vi), 32'(a3_err), 32'(v.err));
    start = 1'b0;
    tick();
    chk($sformatf("v%0d idle_err_kept", vi), 32'(a3_err), 32'(v.err));
    chk($sformatf("v%0d idle_addr_zero", vi), 32'(a3_addr), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    chk_addr = {5'd3, 5'd2, 5'd1};
    chk_data = {32'd0, 32'd7, 32'd2};

    vecs[0] = '{h: 20, x1: 2, x2: 7, x3: 0, lat3: 27, lat0: 24, pass: 1, to: 0, err: 0, fidx: 0, fdata: 0};
    vecs[1] = '{h: -1, x1: 2, x2: 7, x3: 0, lat3: 70, lat0: 67, pass: 0, to: 1, err: 0, fidx: 0, fdata: 0};
`ifdef JEDRO_1_TEST_MON_STOP_ON_FAIL_EN
    vecs[2] = '{h: 10, x1: 2, x2: 5, x3: 9, lat3: 16, lat0: 13, pass: 0, to: 0, err: 1, fidx: 1, fdata: 5};
    vecs[4] = '{h: 0,  x1: 9, x2: 0, x3: 5, lat3: 5,  lat0: 2,  pass: 0, to: 0, err: 1, fidx: 0, fdata: 9};
`else
    vecs[2] = '{h: 10, x1: 2, x2: 5, x3: 9, lat3: 17, lat0: 14, pass: 0, to: 0, err: 2, fidx: 1, fdata: 5};
    vecs[4] = '{h: 0,  x1: 9, x2: 0, x3: 5, lat3: 7,  lat0: 4,  pass: 0, to: 0, err: 3, fidx: 0, fdata: 9};
`endif
    vecs[3] = '{h: 63, x1: 2, x2: 7, x3: 0, lat3: 70, lat0: 67, pass: 1, to: 0, err: 0, fidx: 0, fdata: 0};

    repeat (2) @(negedge clk);
    chk("rst_done", 32'(a3_done), 32'd0);
    chk("rst_pass", 32'(a3_pass), 32'd0);
    chk("rst_timeout", 32'(a3_to), 32'd0);
    chk("rst_err", 32'(a3_err), 32'd0);
    chk("rst_addr", 32'(a3_addr), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_no_start", 32'(a3_done), 32'd0);

    for (int i = 0; i < 5; i++) run_case(i, vecs[i]);

    // Abort during DRAIN, then a clean rerun
    rf[1] = 2; rf[2] = 7; rf[3] = 0;
    start = 1'b1;
    tick();
    tick();
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("d0_check_next_cycle_addr", 32'(a0_addr), 32'd1);
    chk("d3_drain_addr_zero", 32'(a3_addr), 32'd0);
    tick();
    chk("d0_check_k1_addr", 32'(a0_addr), 32'd2);
    start = 1'b0;
    tick();
    chk("abort_done", 32'(a3_done), 32'd0);
    chk("abort_pass", 32'(a3_pass), 32'd0);
    chk("abort_d0_done", 32'(a0_done), 32'd0);
    chk("abort_err", 32'(a3_err), 32'd0);
    run_case(5, vecs[0]);

    // Asynchronous reset while in CHECK with a mismatch recorded
    rf[1] = 9; rf[2] = 7; rf[3] = 0;
    start = 1'b1;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    tick();
    tick();
    chk("chk_k0_addr", 32'(a3_addr), 32'd1);
    tick();
    chk("chk_k1_addr", 32'(a3_addr), 32'd2);
    chk("chk_err_live", 32'(a3_err), 32'd1);
    chk("chk_fdata_live", a3_fdata, 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("arst_err", 32'(a3_err), 32'd0);
    chk("arst_fdata", a3_fdata, 32'd0);
    chk("arst_addr", 32'(a3_addr), 32'd0);
    chk("arst_d0_done", 32'(a0_done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_done", 32'(a3_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
